decode_operand_reader: RTL
==========================

Name: decode_operand_reader

Overview:
- Y86 decode stage: the read-side client of the 8x32 register file.
- Accepts decoded instruction fields from fetch and drives register-file read addresses srcA/srcB.
- Merges register-file data with forwarded results from the execute, memory and writeback stages; stalls on load-use hazards.
- Registers the operands into the D->E pipeline register using a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/data width.
- REG_W, 3, register index width (8 registers).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash: discard the in-flight instruction and the held output
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts the instruction this cycle
- in_icode  in  4  instruction code
- in_rA / in_rB  in  REG_W each  source register indices
- in_useA / in_useB  in  1 each  instruction reads rA / rB
- in_valC  in  DATA_W  immediate
- in_dstE / in_dstM  in  REG_W each  destination indices
- in_dstE_en / in_dstM_en  in  1 each  destination enables
- srcA / srcB  out  REG_W each  register-file read addresses (combinational = in_rA / in_rB)
- rf_valA / rf_valB  in  DATA_W each  register-file combinational read data
- e_dst, e_en, e_val  in  REG_W/1/DATA_W  execute-stage valE bypass
- e_load_dst, e_load_en  in  REG_W/1  load in execute, data not yet available
- mE_dst, mE_en, mE_val  in  REG_W/1/DATA_W  memory-stage valE bypass
- mM_dst, mM_en, mM_val  in  REG_W/1/DATA_W  memory-stage valM bypass
- wE_dst, wE_en, wE_val  in  REG_W/1/DATA_W  writeback valE (same values driven to the register file)
- wM_dst, wM_en, wM_val  in  REG_W/1/DATA_W  writeback valM
- out_valid  out  1  E-stage register holds a valid instruction
- out_ready  in  1  execute accepts it
- out_icode, out_valA, out_valB, out_valC  out  4/DATA_W/DATA_W/DATA_W  registered operands
- out_dstE, out_dstE_en, out_dstM, out_dstM_en  out  registered destinations

Behaviour:
- Reset (synchronous): out_valid=0; every out_* data field=0.
- The register file updates on the clock edge. Same-cycle writeback values are therefore not yet visible in rf_val*, and the W bypass is mandatory.
- Operand select, per port X in {A,B}, with source index r=in_rX. First match wins:
  - e_en && e_dst==r -> e_val
  - mM_en && mM_dst==r -> mM_val
  - mE_en && mE_dst==r -> mE_val
  - wM_en && wM_dst==r -> wM_val
  - wE_en && wE_dst==r -> wE_val
  - otherwise rf_valX.
- When in_useX=0, the operand is rf_valX, with no forwarding and no hazard contribution.
- hazard = in_valid && e_load_en && ((in_useA && in_rA==e_load_dst) || (in_useB && in_rB==e_load_dst)).
- e_load_en has priority over e_en for the same index: hazard stalls regardless of e_en.
- space = !out_valid || out_ready.
- in_ready = flush || (space && !hazard). This is combinational and carries no dependence on in_valid.
- Register update per cycle, evaluated in this priority order:
  1. reset -> cleared.
  2. flush -> out_valid<=0. Any presented input is consumed and dropped.
  3. in_valid && in_ready -> load all out_* from the current selects; out_valid<=1.
  4. space -> out_valid<=0 (bubble inserted on hazard or idle).
  5. Otherwise hold all out_* unchanged (backpressure).
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard.
- A load-use hazard costs exactly one bubble, assuming the load advances to memory the next cycle.
- While out_valid && !out_ready, out_* are stable and in_ready=0 unless flush.
- Index 0 is an ordinary register: no hardwired zero, and it forwards like any other index.

Test Plan:
- Reset, then in_rA=2/in_useA, rf_valA=0x11 with no bypass enables -> next cycle out_valid=1, out_valA=0x11, in_ready held 1.
- Priority: rA=rB=3 with e(3,0xAA), mM(3,0xBB), wE(3,0xCC) all enabled -> out_valA=out_valB=0xAA. Drop e_en -> 0xBB. Drop mM_en -> 0xCC.
- Load-use: e_load_en=1, e_load_dst=5, in_rB=5, in_useB=1 -> in_ready=0 and out_valid=0 next cycle. Clear e_load_en, present mM(5,0x1234) -> accepted, out_valB=0x1234.
- Unused operand: in_useA=0, rA=5, e_load_en=1, e_load_dst=5 -> no stall; out_valA=rf_valA.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with a new input pending -> in_ready=0 and out_* unchanged. Raise out_ready -> new instruction loads on the next edge.
- Flush and reset mid-stall: flush while out_valid=1, out_ready=0 and hazard -> in_ready=1, out_valid=0 next cycle. Reset with out_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_operand_reader_if.sv
// Fetch->decode instruction bundle and decode->execute pipeline-register bundle.
// master = upstream/downstream environment, slave = the decode stage.
interface decode_operand_reader_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic [REG_W-1:0]  in_rA;
  logic [REG_W-1:0]  in_rB;
  logic              in_useA;
  logic              in_useB;
  logic [DATA_W-1:0] in_valC;
  logic [REG_W-1:0]  in_dstE;
  logic [REG_W-1:0]  in_dstM;
  logic              in_dstE_en;
  logic              in_dstM_en;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_icode;
  logic [DATA_W-1:0] out_valA;
  logic [DATA_W-1:0] out_valB;
  logic [DATA_W-1:0] out_valC;
  logic [REG_W-1:0]  out_dstE;
  logic              out_dstE_en;
  logic [REG_W-1:0]  out_dstM;
  logic              out_dstM_en;

  modport master (
    output in_valid, in_icode, in_rA, in_rB, in_useA, in_useB, in_valC,
           in_dstE, in_dstM, in_dstE_en, in_dstM_en, out_ready,
    input  in_ready, out_valid, out_icode, out_valA, out_valB, out_valC,
           out_dstE, out_dstE_en, out_dstM, out_dstM_en
  );

  modport slave (
    input  in_valid, in_icode, in_rA, in_rB, in_useA, in_useB, in_valC,
           in_dstE, in_dstM, in_dstE_en, in_dstM_en, out_ready,
    output in_ready, out_valid, out_icode, out_valA, out_valB, out_valC,
           out_dstE, out_dstE_en, out_dstM, out_dstM_en
  );
endinterface

// File: rtl/decode_operand_reader.sv
// Y86 decode stage: register-file read addressing, operand forwarding from
// E/M/W, load-use stall, and the D->E pipeline register.
module decode_operand_reader #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  decode_operand_reader_if.slave      bus,
  output logic [REG_W-1:0]            srcA,
  output logic [REG_W-1:0]            srcB,
  input  logic [DATA_W-1:0]           rf_valA,
  input  logic [DATA_W-1:0]           rf_valB,
  input  logic [REG_W-1:0]            e_dst,
  input  logic                        e_en,
  input  logic [DATA_W-1:0]           e_val,
  input  logic [REG_W-1:0]            e_load_dst,
  input  logic                        e_load_en,
  input  logic [REG_W-1:0]            mE_dst,
  input  logic                        mE_en,
  input  logic [DATA_W-1:0]           mE_val,
  input  logic [REG_W-1:0]            mM_dst,
  input  logic                        mM_en,
  input  logic [DATA_W-1:0]           mM_val,
  input  logic [REG_W-1:0]            wE_dst,
  input  logic                        wE_en,
  input  logic [DATA_W-1:0]           wE_val,
  input  logic [REG_W-1:0]            wM_dst,
  input  logic                        wM_en,
  input  logic [DATA_W-1:0]           wM_val
);

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              hazard;
  logic              space;
  logic              inReady;

  logic              outValid;
  logic [3:0]        outIcode;
  logic [DATA_W-1:0] outValA;
  logic [DATA_W-1:0] outValB;
  logic [DATA_W-1:0] outValC;
  logic [REG_W-1:0]  outDstE;
  logic              outDstEEn;
  logic [REG_W-1:0]  outDstM;
  logic              outDstMEn;

  // Youngest producer wins; the W bypass covers the register-file write that
  // only lands on this same clock edge.
  function automatic logic [DATA_W-1:0] pickOperand(
    input logic              readsReg,
    input logic [REG_W-1:0]  r,
    input logic [DATA_W-1:0] rfVal
  );
    if (!readsReg)                return rfVal;
    if (e_en  && (e_dst  == r))   return e_val;
    if (mM_en && (mM_dst == r))   return mM_val;
    if (mE_en && (mE_dst == r))   return mE_val;
    if (wM_en && (wM_dst == r))   return wM_val;
    if (wE_en && (wE_dst == r))   return wE_val;
    return rfVal;
  endfunction

  assign srcA = bus.in_rA;
  assign srcB = bus.in_rB;

  // Operand selection and handshake control.
  always_comb begin
    opA     = pickOperand(bus.in_useA, bus.in_rA, rf_valA);
    opB     = pickOperand(bus.in_useB, bus.in_rB, rf_valB);
    hazard  = bus.in_valid && e_load_en &&
              ((bus.in_useA && (bus.in_rA == e_load_dst)) ||
               (bus.in_useB && (bus.in_rB == e_load_dst)));
    space   = !outValid || bus.out_ready;
    inReady = flush || (space && !hazard);
  end

  // D->E pipeline register: reset, flush, load, bubble, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid  <= 1'b0;
      outIcode  <= '0;
      outValA   <= '0;
      outValB   <= '0;
      outValC   <= '0;
      outDstE   <= '0;
      outDstEEn <= 1'b0;
      outDstM   <= '0;
      outDstMEn <= 1'b0;
    end else if (flush) begin
      outValid  <= 1'b0;
    end else if (bus.in_valid && inReady) begin
      outValid  <= 1'b1;
      outIcode  <= bus.in_icode;
      outValA   <= opA;
      outValB   <= opB;
      outValC   <= bus.in_valC;
      outDstE   <= bus.in_dstE;
      outDstEEn <= bus.in_dstE_en;
      outDstM   <= bus.in_dstM;
      outDstMEn <= bus.in_dstM_en;
    end else if (space) begin
      outValid  <= 1'b0;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid;
  assign bus.out_icode   = outIcode;
  assign bus.out_valA    = outValA;
  assign bus.out_valB    = outValB;
  assign bus.out_valC    = outValC;
  assign bus.out_dstE    = outDstE;
  assign bus.out_dstE_en = outDstEEn;
  assign bus.out_dstM    = outDstM;
  assign bus.out_dstM_en = outDstMEn;

endmodule
